// File: rtl/wb_addr_router.sv
// Wishbone address router: fans one slave port out to N_SLAVES downstream slaves by base/mask decode.
// Optional error counter on err_cnt_o is enabled by defining WB_ROUTER_ERRCNT_EN.
module wb_addr_router #(
  parameter int unsigned                N_SLAVES = 2,
  parameter logic [32*N_SLAVES-1:0]     SLV_BASE = {32'h3010_0000, 32'h3800_0000},
  parameter logic [32*N_SLAVES-1:0]     SLV_MASK = {32'hFFF0_0000, 32'hFF00_0000},
  parameter int unsigned                TIMEOUT  = 255,
  parameter logic [31:0]                ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  output logic                       s_we_o,
  output logic [3:0]                 s_sel_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  input  logic [32*N_SLAVES-1:0]     s_dat_i,
  output logic                       err_o,
  output logic [15:0]                err_cnt_o
);

  localparam int unsigned DW       = 32;
  localparam int unsigned IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [TMR_W-1:0]    tmr_q,   tmr_d;
  logic [N_SLAVES-1:0] stb_q,   stb_d;
  logic                we_q,    we_d;
  logic [3:0]          sel_q,   sel_d;
  logic [DW-1:0]       adr_q,   adr_d;
  logic [DW-1:0]       dat_q,   dat_d;
  logic                ack_q,   ack_d;
  logic [DW-1:0]       rdat_q,  rdat_d;
  logic                err_q,   err_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                sel_ack;
  logic [DW-1:0]       sel_dat;
  logic                tmo_hit;

  // Address decode; descending scan so the lowest matching index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if ((wbs_adr_i & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Ack/data of the currently selected slave only; other slaves' acks are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack = s_ack_i[i];
        sel_dat = s_dat_i[32*i +: 32];
      end
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmr_q == TMR_W'(TMO_LAST));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          tmr_d = '0;
          if (dec_hit) begin
            idx_d = dec_idx;
            for (int i = 0; i < int'(N_SLAVES); i++) begin
              stb_d[i] = (dec_idx == IDX_W'(i));
            end
            state_d = ST_FWD;
          end else begin
            rdat_d  = ERR_DATA;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_FWD: begin
        if (!wbs_cyc_i) begin
          // Master abandoned the cycle: release the slave silently.
          stb_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rdat_d  = sel_dat;
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          rdat_d  = ERR_DATA;
          stb_d   = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = stb_q;
  assign s_stb_o   = stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = dat_q;
  assign err_o     = err_q;

`ifdef WB_ROUTER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of error responses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_cnt_q <= '0;
    end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_addr_router.sv
// Self-checking bench for wb_addr_router (TIMEOUT=4, two slaves) with a response scoreboard.
module tb_wb_addr_router;

  localparam int unsigned NS  = 2;
  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

`ifdef WB_ROUTER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [NS-1:0]     s_ack_i;
  logic [32*NS-1:0]  s_dat_i;
  logic              err_o;
  logic [15:0]       err_cnt_o;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t sb_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_errs = 0;

  wb_addr_router #(
    .N_SLAVES (NS),
    .SLV_BASE ({32'h3010_0000, 32'h3800_0000}),
    .SLV_MASK ({32'hFFF0_0000, 32'hFF00_0000}),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERRD)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_ack_i   (s_ack_i),
    .s_dat_i   (s_dat_i),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Every master-side ack must match the oldest outstanding expected response.
  always @(negedge clk) begin
    if (wbs_ack_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("rsp_data", wbs_dat_o, sb_e.data);
        check("rsp_err", 32'(err_o), 32'(sb_e.err));
      end
    end
    if (err_o) check("err_without_ack", 32'(wbs_ack_o), 32'd1);
  end

  // One transaction. idx<0 means unmapped; ack_cyc is the FWD cycle in which the slave acks (0 = never).
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s,
                        input int idx, input int ack_cyc, input bit stray, input logic [31:0] rd);
    bit          tmo_exp;
    bit          err_exp;
    int          stb_n;
    int          lat;
    logic [NS-1:0] oh;
    rsp_t        r;
    tmo_exp = (idx >= 0) && ((ack_cyc == 0) || (ack_cyc > int'(TMO)));
    err_exp = (idx < 0) || tmo_exp;
    stb_n   = (idx < 0) ? 0 : (tmo_exp ? int'(TMO) : ack_cyc);
    oh      = (idx < 0) ? '0 : NS'(1 << idx);
    r.data  = err_exp ? ERRD : rd;
    r.err   = err_exp;
    if (err_exp) exp_errs++;
    lat = 0;

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    s_dat_i = '0;
    if (idx >= 0) begin
      for (int j = 0; j < int'(NS); j++) s_dat_i[32*j +: 32] = (j == idx) ? rd : ~rd;
    end
    sb_q.push_back(r);

    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      s_ack_i = '0;
      if (idx >= 0 && k == ack_cyc) s_ack_i[idx] = 1'b1;
      if (idx >= 0 && stray && (ack_cyc == 0 || k < ack_cyc)) s_ack_i[1 - idx] = 1'b1;
      @(negedge clk);
      check("s_stb", 32'(s_stb_o), 32'((k <= stb_n) ? oh : '0));
      check("s_cyc", 32'(s_cyc_o), 32'((k <= stb_n) ? oh : '0));
      if (k == 1) begin
        check("s_adr", s_adr_o, a);
        check("s_dat", s_dat_o, d);
        check("s_we", 32'(s_we_o), 32'(w));
        check("s_sel", 32'(s_sel_o), 32'(s));
      end
      if (wbs_ack_o) begin
        lat = k + 1;
        break;
      end
    end
    check("ack_latency", 32'(lat), 32'(stb_n + 2));

    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; s_ack_i = '0;
    @(negedge clk);
    check("ack_single", 32'(wbs_ack_o), 32'd0);
    check("dat_hold", wbs_dat_o, r.data);
    check("err_cnt", 32'(err_cnt_o), CNT_EN ? 32'(exp_errs) : 32'd0);
  endtask

  initial begin
    int          kind;
    int          ix;
    logic [31:0] ra;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    s_ack_i = '0; s_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_stb", 32'(s_stb_o), 32'd0);
    check("rst_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_errcnt", 32'(err_cnt_o), 32'd0);
    check("rst_adr", s_adr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency lines: latency checked is request cycle to ack cycle, i.e. stb cycles + 1 (+1 counting the request cycle index).
    do_req(32'h3800_0010, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h1234_5678);
    do_req(32'h3010_0004, 32'hA5A5_0001, 1'b1, 4'hF, 1, 3, 1'b1, 32'h0BAD_F00D);
    do_req(32'h2000_0000, 32'h0, 1'b0, 4'hF, -1, 0, 1'b0, 32'h0);
    do_req(32'h3010_0100, 32'h0, 1'b0, 4'hF, 1, 0, 1'b0, 32'h5555_AAAA);
    do_req(32'h3010_0104, 32'h0, 1'b0, 4'hF, 1, 4, 1'b0, 32'hCAFE_0004);
    do_req(32'h38AB_CDE0, 32'h0000_00C3, 1'b1, 4'h3, 0, 2, 1'b1, 32'h7777_0000);

    // Master abandons the cycle in the second FWD cycle.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3010_0200; wdat = '0;
    @(negedge clk);
    @(negedge clk);
    check("abort_fwd1", 32'(s_stb_o), 32'h2);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_fwd2", 32'(s_stb_o), 32'h2);
    @(negedge clk);
    check("abort_cyc", 32'(s_cyc_o), 32'd0);
    check("abort_stb", 32'(s_stb_o), 32'd0);
    check("abort_ack", 32'(wbs_ack_o), 32'd0);
    @(negedge clk);
    check("abort_ack2", 32'(wbs_ack_o), 32'd0);
    do_req(32'h3800_0040, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h0102_0304);

    // Randomised mix of hits, misses, late acks and timeouts.
    for (int r = 0; r < 10; r++) begin
      kind = $urandom_range(0, 2);
      ra   = $urandom;
      case (kind)
        0:       begin ix = 0;  ra = 32'h3800_0000 | (ra & 32'h00FF_FFFC); end
        1:       begin ix = 1;  ra = 32'h3010_0000 | (ra & 32'h000F_FFFC); end
        default: begin ix = -1; ra = 32'h2000_0000 | (ra & 32'h000F_FFFC); end
      endcase
      do_req(ra, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), ix,
             $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);
    end

    // Synchronous reset while forwarding, then a stray late ack.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3800_0020; wdat = 32'h1111_2222;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_fwd", 32'(s_stb_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; s_ack_i = 2'b01;
    @(negedge clk);
    check("rstmid_stb", 32'(s_stb_o), 32'd0);
    check("rstmid_cyc", 32'(s_cyc_o), 32'd0);
    check("rstmid_ack", 32'(wbs_ack_o), 32'd0);
    check("rstmid_dat", wbs_dat_o, 32'd0);
    check("rstmid_adr", s_adr_o, 32'd0);
    check("rstmid_we", 32'(s_we_o), 32'd0);
    check("rstmid_errcnt", 32'(err_cnt_o), 32'd0);
    exp_errs = 0;
    @(posedge clk); #1;
    s_ack_i = '0;
    @(negedge clk);
    check("stray_ack", 32'(wbs_ack_o), 32'd0);
    do_req(32'h2000_0010, 32'h0, 1'b0, 4'hF, -1, 0, 1'b0, 32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
